iob_nativebridge_arbiter: RTL and testbench
===========================================

// Module: iob_nativebridge_arbiter
// PURPOSE
//  Round-robin arbiter sharing one external native-bridge port (valid/address/wdata/wstrb/rdata/ready)
//  among N_MASTERS native-bus requesters, e.g. CPU and DMA. Sits between the requesters and the bridge.
//  Grants one master, forwards its request and locks the grant until ready_ext, then returns the
//  response (m_ready, m_rdata) to that master only.
// PARAMETERS
//  N_MASTERS      2             number of requesters (>=2)
//  DATA_W         32            data width
//  ADDR_W         16            address width
//  TIMEOUT_W      8             width of timeout counter (TIMEOUT_EN only)
//  ERR_RDATA      32'hDEADBEEF  rdata returned on timeout (TIMEOUT_EN only)
// PORTS
//  clk          in   1                   clock, rising edge
//  rst_n        in   1                   asynchronous active-low reset
//  m_valid      in   N_MASTERS           per-master request, held high until its m_ready
//  m_address    in   N_MASTERS*ADDR_W    per-master address, master i at [i*ADDR_W +: ADDR_W]
//  m_wdata      in   N_MASTERS*DATA_W    per-master write data
//  m_wstrb      in   N_MASTERS*DATA_W/8  per-master byte strobes (0 = read)
//  m_rdata      out  DATA_W              shared read data, valid for the master whose m_ready is high
//  m_ready      out  N_MASTERS           one-hot completion pulse to the granted master
//  valid_ext    out  1                   request to bridge
//  address_ext  out  ADDR_W              latched address of the granted master
//  wdata_ext    out  DATA_W              latched write data
//  wstrb_ext    out  DATA_W/8            latched strobes
//  rdata_ext    in   DATA_W              bridge read data
//  ready_ext    in   1                   bridge completion, 1-cycle pulse
//  timeout_err  out  1                   sticky timeout flag (TIMEOUT_EN only)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, rr_ptr=0, grant=0, valid_ext=0, address/wdata/wstrb_ext=0,
//    m_ready=0, m_rdata=0, timeout_err=0, timeout counter=0.
//  - FSM IDLE: if |m_valid, pick the first requester at or after rr_ptr (cyclically). Latch its
//    address/wdata/wstrb into the *_ext registers, set grant, valid_ext<=1, go BUSY. Else stay.
//  - FSM BUSY: valid_ext=1, *_ext stable. On ready_ext: m_ready[grant]=1 and m_rdata=rdata_ext in the
//    same cycle (combinational from ready_ext). Next edge: valid_ext<=0, rr_ptr<=(grant+1)%N_MASTERS,
//    go IDLE.
//  - Latency: m_valid seen at edge k -> valid_ext high after edge k; m_ready in ready_ext cycle.
//    One IDLE bubble between back-to-back transactions; re-arbitration happens in that IDLE cycle.
//  - m_ready=0 and m_rdata=0 whenever not (BUSY && ready_ext). Never more than one m_ready bit high.
//  - Requests of non-granted masters are ignored in BUSY and wait; no starvation (each waits at most
//    N_MASTERS-1 transactions).
//  - Granted master dropping m_valid during BUSY: transaction still completes, m_ready still pulses.
//  - ready_ext while IDLE: ignored, no m_ready.
//  - rr_ptr wraps from N_MASTERS-1 to 0.
//  - rst_n low mid-transaction: immediate abort to reset values; bridge sees valid_ext fall.
// CONFIGURATION
//  IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN defined: BUSY counter counts from 0 each cycle without
//    ready_ext; when counter == 2**TIMEOUT_W-1, m_ready[grant]=1 with m_rdata=ERR_RDATA, timeout_err<=1
//    (sticky until reset), go IDLE. ready_ext in the same cycle wins (normal completion).
//    The port timeout_err exists.
//  Not defined: no counter, no timeout_err port; BUSY waits indefinitely.
// STRUCTURE
//  iob_nativebridge_arbiter_defs.vh: state encodings (IDLE=1'b0, BUSY=1'b1), ERR_RDATA default,
//    clog2-based GRANT_W macro.
//  Sub-module iob_nativebridge_arbiter_rr_pick: combinational round-robin priority encoder
//    (req vector, rr_ptr -> grant index, any_req).
// TESTING
//  1 Reset: rst_n=0 mid-BUSY -> all outputs 0 in the same cycle; after release, state IDLE.
//  2 Single read: m0 valid, addr 0x0010, wstrb 0 -> valid_ext after 1 edge, address_ext=0x0010;
//    ready_ext with rdata 0x12345678 -> m_ready=2'b01, m_rdata=0x12345678 in that cycle.
//  3 Contention: m0 and m1 valid continuously, rr_ptr=0 -> grant order m0,m1,m0,m1;
//    address_ext alternates; one IDLE cycle between transactions.
//  4 Write: m1 addr 0x0004, wdata 0xA5A5A5A5, wstrb 4'b0011 -> *_ext match exactly and stay stable
//    until ready_ext; m_ready=2'b10.
//  5 Stray ready_ext while IDLE, and m0 dropping valid while BUSY -> no m_ready in IDLE;
//    m_ready[0] still pulses on completion.
//  6 TIMEOUT_EN, TIMEOUT_W=4: no ready_ext -> at BUSY cycle 15, m_ready[grant]=1,
//    m_rdata=0xDEADBEEF, timeout_err=1 and stays 1.

Source files
------------

// File: rtl/iob_nativebridge_arbiter_pkg.sv
// Shared types and constants for the native-bridge round-robin arbiter.
// Contents: FSM state encoding, default timeout read data, and the grant-index width helper.
package iob_nativebridge_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Read data returned to a master whose transaction timed out
  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

  // Width of a master index (at least one bit)
  function automatic int unsigned grant_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_nativebridge_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Returns the first asserted request at or after i_ptr, searching cyclically.
// Ports:
//   i_req     [N_MASTERS-1:0]  request vector
//   i_ptr     [GRANT_W-1:0]    highest-priority index (always < N_MASTERS)
//   o_grant   [GRANT_W-1:0]    selected index (0 when no request)
//   o_any_req                  at least one request asserted
module iob_nativebridge_arbiter_rr_pick #(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned GRANT_W   = 1
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [GRANT_W-1:0]   i_ptr,
  output logic [GRANT_W-1:0]   o_grant,
  output logic                 o_any_req
);

  assign o_any_req = |i_req;

  // Walk offsets from farthest to nearest so the nearest requester wins
  always_comb begin
    o_grant = '0;
    for (int unsigned k = N_MASTERS; k > 0; k--) begin
      if (i_req[(32'(i_ptr) + k - 1) % N_MASTERS]) begin
        o_grant = GRANT_W'((32'(i_ptr) + k - 1) % N_MASTERS);
      end
    end
  end

endmodule

// File: rtl/iob_nativebridge_arbiter.sv
// Round-robin arbiter sharing one native-bridge port among N_MASTERS requesters.
// A granted request is latched into the *_ext registers and held until ready_ext;
// the completion (m_ready, m_rdata) is returned combinationally to the granted master only.
// Optional feature macro: IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
//   adds a BUSY watchdog that completes the transaction with ERR_RDATA and raises the
//   sticky timeout_err output.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   m_valid/m_address/m_wdata/m_wstrb  packed per-master requests (master i at slice i)
//   m_rdata, m_ready               shared read data, one-hot completion pulse
//   valid_ext/address_ext/wdata_ext/wstrb_ext  latched request towards the bridge
//   rdata_ext, ready_ext           bridge response
//   timeout_err                    sticky timeout flag (timeout build only)
module iob_nativebridge_arbiter
  import iob_nativebridge_arbiter_pkg::*;
#(
  parameter int unsigned      N_MASTERS = 2,
  parameter int unsigned      DATA_W    = 32,
  parameter int unsigned      ADDR_W    = 16,
  parameter int unsigned      TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_RDATA_DEF)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          valid_ext,
  output logic [ADDR_W-1:0]             address_ext,
  output logic [DATA_W-1:0]             wdata_ext,
  output logic [DATA_W/8-1:0]           wstrb_ext,
  input  logic [DATA_W-1:0]             rdata_ext,
  input  logic                          ready_ext
`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int unsigned GRANT_W = grant_w(N_MASTERS);
  localparam int unsigned STRB_W  = DATA_W / 8;

  arb_state_e           r_state;
  arb_state_e           w_state_nxt;
  logic [GRANT_W-1:0]   r_grant;
  logic [GRANT_W-1:0]   r_rr_ptr;
  logic                 r_valid_ext;
  logic [ADDR_W-1:0]    r_address_ext;
  logic [DATA_W-1:0]    r_wdata_ext;
  logic [STRB_W-1:0]    r_wstrb_ext;

  logic [GRANT_W-1:0]   w_pick;
  logic                 w_any_req;
  logic [ADDR_W-1:0]    w_sel_address;
  logic [DATA_W-1:0]    w_sel_wdata;
  logic [STRB_W-1:0]    w_sel_wstrb;
  logic                 w_start;
  logic                 w_done;
  logic                 w_timeout;
  logic                 w_complete;
  logic [TIMEOUT_W-1:0] w_tmo_cnt;

  // Round-robin selection among current requesters
  iob_nativebridge_arbiter_rr_pick #(
    .N_MASTERS (N_MASTERS),
    .GRANT_W   (GRANT_W)
  ) u_rr_pick (
    .i_req     (m_valid),
    .i_ptr     (r_rr_ptr),
    .o_grant   (w_pick),
    .o_any_req (w_any_req)
  );

  // Request payload mux for the picked master
  always_comb begin
    w_sel_address = '0;
    w_sel_wdata   = '0;
    w_sel_wstrb   = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (w_pick == GRANT_W'(i)) begin
        w_sel_address = m_address[i*ADDR_W +: ADDR_W];
        w_sel_wdata   = m_wdata[i*DATA_W +: DATA_W];
        w_sel_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  assign w_start    = (r_state == ST_IDLE) && w_any_req;
  assign w_done     = (r_state == ST_BUSY) && ready_ext;
  // A real completion in the same cycle takes precedence over the watchdog
  assign w_timeout  = (r_state == ST_BUSY) && !ready_ext && (w_tmo_cnt == '1);
  assign w_complete = w_done || w_timeout;

`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic                 r_timeout_err;

  // BUSY watchdog: counts cycles without completion, cleared outside BUSY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if ((r_state == ST_BUSY) && !w_complete) begin
        r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign w_tmo_cnt   = r_tmo_cnt;
  assign timeout_err = r_timeout_err;
`else
  // No watchdog: counter tied off so the timeout compare folds to constant 0
  assign w_tmo_cnt = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)    w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_complete) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Completion outputs, combinational from the bridge response
  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    if (w_done) begin
      m_ready[r_grant] = 1'b1;
      m_rdata          = rdata_ext;
    end else if (w_timeout) begin
      m_ready[r_grant] = 1'b1;
      m_rdata          = ERR_RDATA;
    end
  end

  // Grant, round-robin pointer and latched bridge request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant       <= '0;
      r_rr_ptr      <= '0;
      r_valid_ext   <= 1'b0;
      r_address_ext <= '0;
      r_wdata_ext   <= '0;
      r_wstrb_ext   <= '0;
    end else if (w_start) begin
      r_grant       <= w_pick;
      r_valid_ext   <= 1'b1;
      r_address_ext <= w_sel_address;
      r_wdata_ext   <= w_sel_wdata;
      r_wstrb_ext   <= w_sel_wstrb;
    end else if (w_complete) begin
      r_valid_ext <= 1'b0;
      // Lowest priority goes to the master just served
      r_rr_ptr    <= (32'(r_grant) == N_MASTERS - 1) ? '0 : r_grant + GRANT_W'(1);
    end
  end

  assign valid_ext   = r_valid_ext;
  assign address_ext = r_address_ext;
  assign wdata_ext   = r_wdata_ext;
  assign wstrb_ext   = r_wstrb_ext;

endmodule

// File: tb/tb_iob_nativebridge_arbiter.sv
// Self-checking bench for iob_nativebridge_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level round-robin model.
module tb_iob_nativebridge_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TW = 4;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_address;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            valid_ext;
  logic [AW-1:0]   address_ext;
  logic [DW-1:0]   wdata_ext;
  logic [SW-1:0]   wstrb_ext;
  logic [DW-1:0]   rdata_ext;
  logic            ready_ext;
`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
  logic            timeout_err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  iob_nativebridge_arbiter #(
    .N_MASTERS (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_valid     (m_valid),
    .m_address   (m_address),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .valid_ext   (valid_ext),
    .address_ext (address_ext),
    .wdata_ext   (wdata_ext),
    .wstrb_ext   (wstrb_ext),
    .rdata_ext   (rdata_ext),
    .ready_ext   (ready_ext)
`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [SW-1:0] s);
    m_address[i*AW +: AW] = a;
    m_wdata[i*DW +: DW]   = d;
    m_wstrb[i*SW +: SW]   = s;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    m_valid   = '0;
    m_address = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    rdata_ext = '0;
    ready_ext = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (valid_ext !== 1'b0) $display("FAIL reset_valid_ext: got %b want 0", valid_ext); else n_pass++;
    n_checks++; if (address_ext !== '0) $display("FAIL reset_address_ext: got %h want 0", address_ext); else n_pass++;
    n_checks++; if (m_ready !== '0) $display("FAIL reset_m_ready: got %b want 0", m_ready); else n_pass++;
    n_checks++; if (m_rdata !== '0) $display("FAIL reset_m_rdata: got %h want 0", m_rdata); else n_pass++;
    // Reset in the middle of a transaction
    set_master(0, 16'h0ABC, 32'h11112222, 4'hF);
    m_valid = 2'b01;
    cyc();
    n_checks++; if (valid_ext !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", valid_ext); else n_pass++;
    ready_ext = 1'b1;
    rdata_ext = 32'hCAFEF00D;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (valid_ext !== 1'b0) $display("FAIL reset_mid_valid_ext: got %b want 0", valid_ext); else n_pass++;
    n_checks++; if (m_ready !== '0) $display("FAIL reset_mid_m_ready: got %b want 0", m_ready); else n_pass++;
    n_checks++; if (m_rdata !== '0) $display("FAIL reset_mid_m_rdata: got %h want 0", m_rdata); else n_pass++;
    n_checks++; if ({address_ext, wdata_ext, wstrb_ext} !== '0)
      $display("FAIL reset_mid_ext: got %h/%h/%h want 0", address_ext, wdata_ext, wstrb_ext); else n_pass++;
    m_valid = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    // Back in IDLE: stray ready is ignored, nothing requested
    #1;
    n_checks++; if (m_ready !== '0 || valid_ext !== 1'b0)
      $display("FAIL reset_after_idle: got ready %b valid %b want 0 0", m_ready, valid_ext); else n_pass++;
    ready_ext = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    set_master(0, 16'h0010, 32'h0, 4'h0);
    m_valid = 2'b01;
    #1;
    n_checks++; if (valid_ext !== 1'b0) $display("FAIL read_before_edge: got %b want 0", valid_ext); else n_pass++;
    cyc();
    n_checks++; if (valid_ext !== 1'b1) $display("FAIL read_valid_ext: got %b want 1", valid_ext); else n_pass++;
    n_checks++; if (address_ext !== 16'h0010) $display("FAIL read_address_ext: got %h want 0010", address_ext); else n_pass++;
    n_checks++; if (wstrb_ext !== 4'h0) $display("FAIL read_wstrb_ext: got %h want 0", wstrb_ext); else n_pass++;
    n_checks++; if (m_ready !== '0) $display("FAIL read_no_early_ready: got %b want 00", m_ready); else n_pass++;
    ready_ext = 1'b1;
    rdata_ext = 32'h12345678;
    #1;
    n_checks++; if (m_ready !== 2'b01) $display("FAIL read_m_ready: got %b want 01", m_ready); else n_pass++;
    n_checks++; if (m_rdata !== 32'h12345678) $display("FAIL read_m_rdata: got %h want 12345678", m_rdata); else n_pass++;
    cyc();
    ready_ext = 1'b0;
    m_valid   = '0;
    #1;
    n_checks++; if (valid_ext !== 1'b0 || m_ready !== '0)
      $display("FAIL read_after: got valid %b ready %b want 0 00", valid_ext, m_ready); else n_pass++;
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_a;
    logic [N-1:0]  exp_r;
    do_reset();
    set_master(0, 16'h0100, 32'hA0A0A0A0, 4'h0);
    set_master(1, 16'h0200, 32'hB0B0B0B0, 4'h0);
    m_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_a = (t % 2 == 0) ? 16'h0100 : 16'h0200;
      exp_r = (t % 2 == 0) ? 2'b01 : 2'b10;
      cyc();
      n_checks++; if (valid_ext !== 1'b1 || address_ext !== exp_a)
        $display("FAIL contention_grant%0d: got valid %b addr %h want 1 %h", t, valid_ext, address_ext, exp_a); else n_pass++;
      ready_ext = 1'b1;
      rdata_ext = $urandom;
      #1;
      n_checks++; if (m_ready !== exp_r)
        $display("FAIL contention_ready%0d: got %b want %b", t, m_ready, exp_r); else n_pass++;
      cyc();
      ready_ext = 1'b0;
      n_checks++; if (valid_ext !== 1'b0)
        $display("FAIL contention_bubble%0d: got %b want 0", t, valid_ext); else n_pass++;
    end
    m_valid = '0;
  endtask

  task automatic test_write();
    do_reset();
    set_master(1, 16'h0004, 32'hA5A5A5A5, 4'b0011);
    m_valid = 2'b10;
    cyc();
    n_checks++; if ({address_ext, wdata_ext, wstrb_ext} !== {16'h0004, 32'hA5A5A5A5, 4'b0011})
      $display("FAIL write_ext: got %h/%h/%h want 0004/a5a5a5a5/3", address_ext, wdata_ext, wstrb_ext); else n_pass++;
    // Master changes its bus while waiting; the latched request must not move
    set_master(1, 16'hFFFF, 32'h0, 4'hF);
    for (int c = 0; c < 3; c++) begin
      cyc();
      n_checks++; if ({valid_ext, address_ext, wdata_ext, wstrb_ext} !== {1'b1, 16'h0004, 32'hA5A5A5A5, 4'b0011})
        $display("FAIL write_stable%0d: got %b/%h/%h/%h want 1/0004/a5a5a5a5/3", c, valid_ext, address_ext, wdata_ext, wstrb_ext); else n_pass++;
    end
    ready_ext = 1'b1;
    #1;
    n_checks++; if (m_ready !== 2'b10) $display("FAIL write_m_ready: got %b want 10", m_ready); else n_pass++;
    cyc();
    ready_ext = 1'b0;
    m_valid   = '0;
  endtask

  task automatic test_stray_and_drop();
    do_reset();
    ready_ext = 1'b1;
    rdata_ext = 32'h55AA55AA;
    #1;
    n_checks++; if (m_ready !== '0 || m_rdata !== '0)
      $display("FAIL stray_idle: got ready %b rdata %h want 00 0", m_ready, m_rdata); else n_pass++;
    cyc();
    ready_ext = 1'b0;
    set_master(0, 16'h0042, 32'h0, 4'h0);
    m_valid = 2'b01;
    cyc();
    m_valid = '0;
    cyc();
    n_checks++; if (valid_ext !== 1'b1) $display("FAIL drop_still_busy: got %b want 1", valid_ext); else n_pass++;
    ready_ext = 1'b1;
    rdata_ext = 32'h0BADF00D;
    #1;
    n_checks++; if (m_ready !== 2'b01 || m_rdata !== 32'h0BADF00D)
      $display("FAIL drop_complete: got ready %b rdata %h want 01 0badf00d", m_ready, m_rdata); else n_pass++;
    cyc();
    ready_ext = 1'b0;
  endtask

`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int early;
    early = 0;
    do_reset();
    set_master(1, 16'h0777, 32'h0, 4'h0);
    m_valid = 2'b10;
    cyc();
    // BUSY cycle 0 through 14: no completion yet
    for (int c = 0; c < 15; c++) begin
      if (m_ready !== '0 || valid_ext !== 1'b1) early++;
      if (c < 14) cyc();
    end
    n_checks++; if (early != 0) $display("FAIL timeout_early: got %0d bad cycles want 0", early); else n_pass++;
    cyc();
    n_checks++; if (m_ready !== 2'b10 || m_rdata !== 32'hDEADBEEF)
      $display("FAIL timeout_fire: got ready %b rdata %h want 10 deadbeef", m_ready, m_rdata); else n_pass++;
    cyc();
    m_valid = '0;
    n_checks++; if (timeout_err !== 1'b1 || valid_ext !== 1'b0)
      $display("FAIL timeout_err_set: got err %b valid %b want 1 0", timeout_err, valid_ext); else n_pass++;
    repeat (3) cyc();
    n_checks++; if (timeout_err !== 1'b1) $display("FAIL timeout_err_sticky: got %b want 1", timeout_err); else n_pass++;
  endtask
`endif

  // Randomized traffic against a transaction-level round-robin model
  task automatic test_random();
    logic [N-1:0]  pend;
    logic [AW-1:0] a [N];
    logic [DW-1:0] d [N];
    logic [SW-1:0] s [N];
    int unsigned   waited [N];
    int unsigned   max_wait;
    bit            busy;
    int unsigned   ptr, gnt, busy_len, n_txn;
    logic [N-1:0]  exp_r;
    logic [DW-1:0] exp_d;
    int            errs;
    pend = '0; busy = 0; ptr = 0; gnt = 0; busy_len = 0; n_txn = 0; max_wait = 0; errs = 0;
    for (int i = 0; i < N; i++) waited[i] = 0;
    do_reset();
    for (int cy = 0; cy < 800; cy++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          a[i] = AW'($urandom);
          d[i] = $urandom;
          s[i] = SW'($urandom);
          set_master(i, a[i], d[i], s[i]);
        end
      end
      m_valid   = pend;
      ready_ext = busy ? (busy_len >= 6 || $urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      rdata_ext = $urandom;
      #1;
      exp_r = (busy && ready_ext) ? (N'(1) << gnt) : '0;
      exp_d = (busy && ready_ext) ? rdata_ext : '0;
      if (valid_ext !== busy || m_ready !== exp_r || m_rdata !== exp_d ||
          (busy && {address_ext, wdata_ext, wstrb_ext} !== {a[gnt], d[gnt], s[gnt]})) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random_cycle%0d: got valid %b ready %b rdata %h addr %h want valid %b ready %b rdata %h addr %h",
                   cy, valid_ext, m_ready, m_rdata, address_ext, busy, exp_r, exp_d, a[gnt]);
      end
      @(posedge clk);
      if (busy && ready_ext) begin
        busy = 0;
        pend[gnt] = 1'b0;
        ptr = (gnt + 1) % N;
        n_txn++;
      end else if (!busy && |pend) begin
        for (int k = N - 1; k >= 0; k--) if (pend[(ptr + k) % N]) gnt = (ptr + k) % N;
        for (int i = 0; i < N; i++) if (pend[i] && i != gnt) waited[i]++;
        if (waited[gnt] > max_wait) max_wait = waited[gnt];
        waited[gnt] = 0;
        busy = 1;
        busy_len = 0;
      end
      if (busy) busy_len++;
      #1;
    end
    n_checks++; if (errs != 0) $display("FAIL random_model: got %0d bad cycles want 0", errs); else n_pass++;
    n_checks++; if (max_wait > N - 1) $display("FAIL random_starvation: got wait %0d want <= %0d", max_wait, N - 1); else n_pass++;
    n_checks++; if (n_txn < 50) $display("FAIL random_progress: got %0d transactions want >= 50", n_txn); else n_pass++;
    m_valid   = '0;
    ready_ext = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_stray_and_drop();
`ifdef IOB_NATIVEBRIDGE_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
